// File: rtl/user_event_queue.sv
// Button front end and event queue. It synchronizes and debounces five buttons, turns presses and auto-repeats into pending flags,
// and drains those flags by priority into a first-word-fall-through queue. Press to ready latency on an empty queue is DEBOUNCE_CYCLES+4.
module user_event_queue #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_START    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] btn_i,
  output logic [2:0] user_event_o,
  output logic       user_event_ready_o,
  input  logic       user_event_rd_req_i,
  output logic       overflow_o
);

  localparam logic [2:0] EV_LEFT     = 3'd1;
  localparam logic [2:0] EV_RIGHT    = 3'd2;
  localparam logic [2:0] EV_DOWN     = 3'd3;
  localparam logic [2:0] EV_ROTATE   = 3'd4;
  localparam logic [2:0] EV_NEW_GAME = 3'd5;

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RS_LAST = RPT_W'(REPEAT_START);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [4:0]       sync_p0, sync_p1;
  logic [4:0]       level_p2, level_d_p3, pending_p3;
  logic [DB_W-1:0]  db_cnt [5];
  logic [RPT_W-1:0] rep_cnt [3];
  logic [2:0]       rep_phase, rep_fire;
  logic [4:0]       press, sel_mask;
  logic             sel_vld;
  logic [2:0]       sel_code;
  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             full, pop, push;

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_i;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounced level, any disagreement gap restarts the count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_p2   <= '0;
      level_d_p3 <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      level_d_p3 <= level_p2;
      for (int i = 0; i < 5; i++) begin
        if (sync_p1[i] == level_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]   <= '0;
          level_p2[i] <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Auto-repeat for left/right/down: first shot after REPEAT_START, then each REPEAT_PERIOD
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 3; i++)
      rep_fire[i] = level_p2[i] && (rep_phase[i] ? (rep_cnt[i] == RP_LAST) : (rep_cnt[i] == RS_LAST));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rep_phase <= '0;
      for (int i = 0; i < 3; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!level_p2[i]) begin
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rep_cnt[i]   <= RPT_W'(1);
          rep_phase[i] <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = level_p2 & ~level_d_p3;

  // Stage p3: pending flags, one drained per cycle by fixed priority
  always_comb begin
    sel_vld  = 1'b1;
    sel_code = 3'd0;
    sel_mask = 5'b00000;
    if (pending_p3[4]) begin
      sel_code = EV_NEW_GAME; sel_mask = 5'b10000;
    end else if (pending_p3[3]) begin
      sel_code = EV_ROTATE;   sel_mask = 5'b01000;
    end else if (pending_p3[2]) begin
      sel_code = EV_DOWN;     sel_mask = 5'b00100;
    end else if (pending_p3[0]) begin
      sel_code = EV_LEFT;     sel_mask = 5'b00001;
    end else if (pending_p3[1]) begin
      sel_code = EV_RIGHT;    sel_mask = 5'b00010;
    end else begin
      sel_vld = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_p3 <= '0;
    else       pending_p3 <= (pending_p3 & ~sel_mask) | press | {2'b00, rep_fire};
  end

  // Stage p4: FWFT queue; a pop frees the slot for a same-cycle write
  assign full = (count == FULL_CNT);
  assign pop  = user_event_rd_req_i & user_event_ready_o;
  assign push = sel_vld & (~full | pop);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      user_event_ready_o <= 1'b0;
      overflow_o         <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count              <= count_nxt;
      user_event_ready_o <= (count_nxt != '0);
      overflow_o         <= sel_vld & full & ~pop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= sel_code;
  end

  assign user_event_o = user_event_ready_o ? mem[rd_ptr] : 3'd0;

endmodule

// File: doc/user_event_queue.md
USER_EVENT_QUEUE -- requirements
Module: user_event_queue

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have parameter REPEAT_START, default 12500000: held-cycles before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 2500000: cycles between auto-repeats.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): event queue entries.
REQ-005 clk_i  in  1  system clock.
REQ-006 rst_i  in  1  reset, asynchronous, active-high; clock clk_i.
REQ-007 btn_i  in  5  raw asynchronous buttons, active-high: [0] left, [1] right, [2] down, [3] rotate, [4] new game.
REQ-008 user_event_o  out  3  head-of-queue event code (EV_LEFT, EV_RIGHT, EV_DOWN, EV_ROTATE, EV_NEW_GAME from the shared defines header).
REQ-009 user_event_ready_o  out  1  queue non-empty; user_event_o valid.
REQ-010 user_event_rd_req_i  in  1  consumer pop request.
REQ-011 overflow_o  out  1  one-cycle pulse when an event is dropped because the queue is full.

Function
REQ-012 Each btn_i bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per button, the debounced level SHALL take the synchronized value only after that value differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the counter from 0.
REQ-014 A 0->1 transition of a debounced level SHALL set that button's pending flag; a 1->0 transition SHALL NOT generate an event.
REQ-015 For left, right and down only: while the debounced level stays 1, a repeat counter SHALL set the pending flag REPEAT_START cycles after the press, then every REPEAT_PERIOD cycles; release clears the counter.
REQ-016 Rotate and new game SHALL NOT auto-repeat.
REQ-017 Setting an already-set pending flag SHALL merge: at most one outstanding event per button.
REQ-018 Each cycle the highest-priority set pending flag SHALL be cleared and its code written to the queue; priority new game > rotate > down > left > right; remaining flags wait for later cycles.
REQ-019 If the queue is full and no pop occurs that cycle, the selected event SHALL be dropped, its flag cleared, and overflow_o pulsed for one cycle.
REQ-020 If the queue is full and a pop occurs in the same cycle, the write SHALL succeed (no overflow).
REQ-021 The queue SHALL be first-word-fall-through: user_event_o shows the oldest entry whenever user_event_ready_o is 1.
REQ-022 user_event_ready_o SHALL be registered and equal (count != 0) after each edge.
REQ-023 user_event_rd_req_i with user_event_ready_o=1 SHALL pop the head at that edge; with user_event_ready_o=0 it SHALL be ignored.
REQ-024 Simultaneous write and pop on a non-empty queue SHALL leave count unchanged.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be wide enough to hold FIFO_DEPTH.
REQ-026 Latency: a clean press SHALL reach user_event_ready_o=1 (on an empty queue) exactly DEBOUNCE_CYCLES+4 cycles after btn_i rises, to be stated by the implementation and held fixed.
REQ-027 user_event_o SHALL be 0 when the queue is empty.

Reset
REQ-028 On rst_i: synchronizers, debounced levels, counters, pending flags cleared; queue empty; user_event_o=0, user_event_ready_o=0, overflow_o=0.
REQ-029 Reset mid-operation SHALL discard all queued and pending events.
REQ-030 A button held through reset release SHALL produce exactly one press event after debounce.

Verification (DEBOUNCE_CYCLES=4, REPEAT_START=20, REPEAT_PERIOD=8, FIFO_DEPTH=4)
REQ-031 Single rotate press held 100 cycles, rd_req tied 1 -> exactly one EV_ROTATE popped, ready at cycle 8 after press.
REQ-032 Left held 60 cycles, rd_req tied 1 -> EV_LEFT events at press, +20, +28, +36, +44, +52 (6 total).
REQ-033 Bounce: btn_i[2] toggles every 2 cycles for 20 cycles then settles 0 -> no event.
REQ-034 left, rotate, new game rise same cycle -> queue order EV_NEW_GAME, EV_ROTATE, EV_LEFT.
REQ-035 rd_req held 0, six distinct presses -> 4 entries kept in order, overflow_o pulses twice, ready stays 1.
REQ-036 Queue holds 2 entries, rst_i pulsed -> ready=0, event=0 next cycle; no stale events after release.
